prbs_checker: RTL and testbench

- Serial PRBS receiver/checker: the reading end of the pseudo-random bit stream that benches and source blocks drive into a DUT.
- Self-synchronises an internal LFSR to the incoming bits, declares lock, then counts bit errors.
- Sits at the sink of any serial data path under test; status outputs are read by the bench or a CSR block.

---
 rtl/prbs_pkg.sv | 16 +
 rtl/prbs_lfsr.sv | 33 +++
 rtl/prbs_checker.sv | 130 +++++++++++++
 tb/tb_prbs_checker.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/prbs_pkg.sv
// Shared PRBS definitions: FSM states, standard tap masks and the feedback
// function used by both checkers and generators.
package prbs_pkg;

  typedef enum logic {HUNT, LOCKED} prbs_state_e;

  localparam logic [6:0]  PRBS7_TAPS  = 7'h60;
  localparam logic [14:0] PRBS15_TAPS = 15'h6000;
  localparam logic [30:0] PRBS31_TAPS = 31'h48000000;

  // Callers zero-extend their register and mask to 64 bits.
  function automatic logic prbs_next(input logic [63:0] lfsr, input logic [63:0] taps);
    return ^(lfsr & taps);
  endfunction

endpackage

// File: rtl/prbs_lfsr.sv
// Parametrised Fibonacci LFSR with next-bit prediction; shifts in either an
// external bit or its own feedback. Shared by checker and generator.
module prbs_lfsr
  import prbs_pkg::*;
#(
  parameter int unsigned       W    = 7,
  parameter logic [W-1:0]      TAPS = PRBS7_TAPS
) (
  input  logic clk,
  input  logic rst_n,
  input  logic adv,
  input  logic load_ext,
  input  logic ext_bit,
  output logic pred,
  output logic nonzero
);

  logic [W-1:0] lfsr_q;

  always_comb begin
    pred    = prbs_next(64'(lfsr_q), 64'(TAPS));
    nonzero = |lfsr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= '0;
    end else if (adv) begin
      lfsr_q <= {lfsr_q[W-2:0], load_ext ? ext_bit : pred};
    end
  end

endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising PRBS checker: hunts for lock, then counts bit errors.
// Define PRBS_CHECKER_BITCNT_EN to add the locked valid-bit counter bit_count.
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int unsigned          LFSR_W    = 7,
  parameter logic [LFSR_W-1:0]    TAPS      = PRBS7_TAPS,
  parameter int unsigned          LOCK_CNT  = 16,
  parameter int unsigned          WIN_LEN   = 64,
  parameter int unsigned          ERR_LIMIT = 8,
  parameter int unsigned          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             clr,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count
`ifdef PRBS_CHECKER_BITCNT_EN
  ,
  output logic [31:0]      bit_count
`endif
);

  localparam int unsigned MW = $clog2(LOCK_CNT + 1);
  localparam int unsigned WW = $clog2(WIN_LEN + 1);
  localparam logic [MW-1:0] LOCK_LAST = MW'(LOCK_CNT - 1);
  localparam logic [WW-1:0] WIN_LAST  = WW'(WIN_LEN - 1);
  localparam logic [WW-1:0] ERR_LAST  = WW'(ERR_LIMIT - 1);

  prbs_state_e   state_q;
  logic [MW-1:0] match_cnt_q;
  logic [WW-1:0] win_bits_q;
  logic [WW-1:0] win_err_q;
  logic          pred;
  logic          nonzero;
  logic          match;
  logic          hit;

  prbs_lfsr #(
    .W    (LFSR_W),
    .TAPS (TAPS)
  ) u_lfsr (
    .clk      (clk),
    .rst_n    (rst_n),
    .adv      (in_valid && !clr),
    .load_ext (state_q == HUNT),
    .ext_bit  (in_bit),
    .pred     (pred),
    .nonzero  (nonzero)
  );

  // An all-zero register predicts 0 forever, so it must never score a match.
  always_comb begin
    match = (pred == in_bit);
    hit   = match && nonzero;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HUNT;
      locked      <= 1'b0;
      err_pulse   <= 1'b0;
      err_count   <= '0;
      match_cnt_q <= '0;
      win_bits_q  <= '0;
      win_err_q   <= '0;
    end else begin
      err_pulse <= 1'b0;
      if (clr) begin
        state_q     <= HUNT;
        locked      <= 1'b0;
        err_count   <= '0;
        match_cnt_q <= '0;
        win_bits_q  <= '0;
        win_err_q   <= '0;
      end else if (in_valid) begin
        unique case (state_q)
          HUNT: begin
            if (!hit) begin
              match_cnt_q <= '0;
            end else if (match_cnt_q == LOCK_LAST) begin
              state_q     <= LOCKED;
              locked      <= 1'b1;
              match_cnt_q <= '0;
            end else begin
              match_cnt_q <= match_cnt_q + MW'(1);
            end
          end
          LOCKED: begin
            if (!match) begin
              err_pulse <= 1'b1;
              if (err_count != '1) err_count <= err_count + CNT_W'(1);
            end
            // Loss of lock wins over a window rollover on the same bit.
            if (!match && win_err_q == ERR_LAST) begin
              state_q     <= HUNT;
              locked      <= 1'b0;
              match_cnt_q <= '0;
              win_bits_q  <= '0;
              win_err_q   <= '0;
            end else if (win_bits_q == WIN_LAST) begin
              win_bits_q <= '0;
              win_err_q  <= '0;
            end else begin
              win_bits_q <= win_bits_q + WW'(1);
              win_err_q  <= win_err_q + WW'(!match);
            end
          end
          default: state_q <= HUNT;
        endcase
      end
    end
  end

`ifdef PRBS_CHECKER_BITCNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_count <= '0;
    end else if (clr) begin
      bit_count <= '0;
    end else if (in_valid && state_q == LOCKED && bit_count != '1) begin
      bit_count <= bit_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker: PRBS7 from seed 7'h7F locks on bit index 22
// (bits 7..22 are the first 16 matches, the register being zero before bit 7).
module tb_prbs_checker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_bit;
  logic        clr;
  logic        locked;
  logic        err_pulse;
  logic [15:0] err_count;
`ifdef PRBS_CHECKER_BITCNT_EN
  logic [31:0] bit_count;
`endif

  int unsigned tests = 0;
  int unsigned fails = 0;
  logic [6:0]  g;

  prbs_checker #(
    .LFSR_W    (7),
    .TAPS      (7'h60),
    .LOCK_CNT  (16),
    .WIN_LEN   (64),
    .ERR_LIMIT (8),
    .CNT_W     (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_bit    (in_bit),
    .clr       (clr),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_count (err_count)
`ifdef PRBS_CHECKER_BITCNT_EN
    ,
    .bit_count (bit_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic b);
    in_valid = v;
    in_bit   = b;
    clr      = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Sends the next generator bit (optionally inverted); generator advances only on valid.
  task automatic send(input logic flip, input logic v);
    drive(v, (g[6] ^ g[5]) ^ flip);
    if (v) g = {g[5:0], g[6] ^ g[5]};
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_bit   = 1'b0;
    clr      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    g     = 7'h7F;
  endtask

  initial begin
    int unsigned vb;
    int unsigned pulses;
    logic        v;
    logic        fl;
    logic        any_lock;

    // Test 1: reset values, lock point, clean run of 1000 locked bits
    do_reset();
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_pulse", 32'(err_pulse), 32'd0);
    chk("rst_count", 32'(err_count), 32'd0);
    pulses = 0;
    for (int unsigned k = 0; k < 1023; k++) begin
      send(1'b0, 1'b1);
      if (k == 21) chk("t1_prelock", 32'(locked), 32'd0);
      if (k == 22) chk("t1_lock", 32'(locked), 32'd1);
      if (err_pulse) pulses++;
    end
    chk("t1_pulses", pulses, 32'd0);
    chk("t1_count", 32'(err_count), 32'd0);
    chk("t1_locked_end", 32'(locked), 32'd1);
`ifdef PRBS_CHECKER_BITCNT_EN
    chk("t1_bitcnt", bit_count, 32'd1000);
`endif

    // Test 2: isolated errors at bits 100, 200, 300
    do_reset();
    for (int unsigned k = 0; k <= 400; k++) begin
      fl = (k == 100 || k == 200 || k == 300);
      send(fl, 1'b1);
      if (k >= 22) chk("t2_pulse", 32'(err_pulse), 32'(fl));
    end
    chk("t2_count", 32'(err_count), 32'd3);
    chk("t2_locked", 32'(locked), 32'd1);

    // Test 3: 7 errors ending on a window's last bit, then 8 in the next window
    do_reset();
    for (int unsigned k = 0; k <= 230; k++) begin
      fl = ((k >= 138 && k <= 150) || (k >= 160 && k <= 174)) && (k % 2 == 0);
      send(fl, 1'b1);
      if (k == 150) begin
        chk("t3_win_edge_lock", 32'(locked), 32'd1);
        chk("t3_win_edge_cnt", 32'(err_count), 32'd7);
      end
      if (k == 172) chk("t3_seven_lock", 32'(locked), 32'd1);
      if (k == 174) begin
        chk("t3_lost", 32'(locked), 32'd0);
        chk("t3_lost_cnt", 32'(err_count), 32'd15);
        chk("t3_lost_pulse", 32'(err_pulse), 32'd1);
      end
      if (k == 175) chk("t3_hunt_pulse", 32'(err_pulse), 32'd0);
      if (k == 189) chk("t3_prerelock", 32'(locked), 32'd0);
      if (k == 190) chk("t3_relock", 32'(locked), 32'd1);
    end
    chk("t3_count_kept", 32'(err_count), 32'd15);

    // Test 4: stuck-at-0 stream never locks
    do_reset();
    any_lock = 1'b0;
    for (int unsigned k = 0; k < 200; k++) begin
      drive(1'b1, 1'b0);
      any_lock = any_lock | locked;
    end
    chk("t4_nolock", 32'(any_lock), 32'd0);
    chk("t4_count", 32'(err_count), 32'd0);

    // Test 5: 50% valid gaps, lock counted in valid bits; then clr while locked
    do_reset();
    vb = 0;
    for (int unsigned c = 0; c < 400 && vb < 60; c++) begin
      v = 1'($urandom_range(0, 1));
      send(1'b0, v);
      if (v) vb++;
      chk("t5_lock", 32'(locked), 32'(vb >= 23));
    end
    chk("t5_budget", vb, 32'd60);
    chk("t5_count", 32'(err_count), 32'd0);
    send(1'b1, 1'b1);
    chk("t5_err_count", 32'(err_count), 32'd1);
    chk("t5_err_pulse", 32'(err_pulse), 32'd1);
    in_valid = 1'b1;
    in_bit   = ~in_bit;
    clr      = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    chk("t5_clr_locked", 32'(locked), 32'd0);
    chk("t5_clr_count", 32'(err_count), 32'd0);
    chk("t5_clr_pulse", 32'(err_pulse), 32'd0);
    for (int unsigned k = 1; k <= 16; k++) begin
      send(1'b0, 1'b1);
      if (k == 15) chk("t5_prerelock", 32'(locked), 32'd0);
      if (k == 16) chk("t5_relock", 32'(locked), 32'd1);
    end

    // Test 6: asynchronous reset mid-cycle while locked, then fresh relock
    send(1'b1, 1'b1);
    chk("t6_pre_count", 32'(err_count), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_async_locked", 32'(locked), 32'd0);
    chk("t6_async_pulse", 32'(err_pulse), 32'd0);
    chk("t6_async_count", 32'(err_count), 32'd0);
`ifdef PRBS_CHECKER_BITCNT_EN
    chk("t6_async_bitcnt", bit_count, 32'd0);
`endif
    #2;
    rst_n = 1'b1;
    g     = 7'h7F;
    for (int unsigned k = 0; k <= 22; k++) begin
      send(1'b0, 1'b1);
      if (k == 21) chk("t6_prerelock", 32'(locked), 32'd0);
      if (k == 22) chk("t6_relock", 32'(locked), 32'd1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
